onehot_mux_stream: RTL
======================

// Module: onehot_mux_stream
// PURPOSE
//  Registered, flow-controlled successor of the combinational one-hot mux.
//  Selects one of N DW-bit channels with a one-hot sel and forwards the beat
//  through a valid/ready stage with a 2-entry skid buffer, so i_ready is driven
//  from a flop. It flags non-one-hot selects and keeps a saturating error count.
//  Used between datapath stages where the mux would otherwise close timing badly.
// PARAMETERS
//  DW        8  width of each channel and of o
//  N         4  number of channels (>=2); sel width
//  CHECK     1  1: one-hot checking and err_count enabled; 0: o_err=0, count held 0
//  ERR_CNT_W 8  width of the saturating error counter
// PORTS
//  clk        in   1     clock, all logic rising-edge
//  aresetn    in   1     asynchronous active-low reset
//  sel        in   N     one-hot channel select, sampled with i_valid
//  i          in   N*DW  channel j at i[(j+1)*DW-1 -: DW]
//  i_valid    in   1     input beat valid
//  i_ready    out  1     stage can accept a beat (registered)
//  o          out  DW    selected data (registered)
//  o_err      out  1     sel of this output beat was not one-hot
//  o_valid    out  1     output beat valid
//  o_ready    in   1     downstream accepts output beat
//  err_clr    in   1     synchronous clear of err_count
//  err_count  out  ERR_CNT_W  accepted beats with bad sel, saturating
// BEHAVIOUR
//  Reset (aresetn low, async): o=0, o_err=0, o_valid=0, i_ready=0,
//   skid empty, err_count=0. i_ready rises on the first clk edge after release.
//  Data select: d = OR over j of ({DW{sel[j]}} & chan j); sel=0 -> d=0;
//   multiple bits -> OR of selected channels (same as combinational mux).
//  Bad sel: CHECK=1 and $countones(sel)!=1; travels with the beat as o_err.
//  Transfer in  = i_valid & i_ready; transfer out = o_valid & o_ready.
//  sel/i/i_valid may change freely when no transfer in occurs.
//  States (occupancy): EMPTY(0), ONE(out reg full), TWO(out + skid full).
//   EMPTY: in -> ONE (beat to out reg).
//   ONE:   in&out -> ONE (new beat to out reg); in&!out -> TWO (beat to skid);
//          !in&out -> EMPTY; else hold.
//   TWO:   out -> ONE (skid moves to out reg); else hold. i_ready=0 in TWO.
//  i_ready registered: 1 in EMPTY/ONE, 0 in TWO, 0 while in reset.
//  Latency: beat accepted at edge k is on o with o_valid at edge k+1 when
//   out reg was free or drained same cycle. Throughput 1 beat/cycle with
//   o_ready held high. Order strictly preserved; no beat dropped/duplicated.
//  o/o_err stable while o_valid & !o_ready.
//  err_count: +1 on each transfer in with bad sel; saturates at all-ones;
//   err_clr forces 0 and wins over a simultaneous increment.
//  Reset mid-operation: in-flight beats discarded, outputs return to reset values.
// TESTING
//  1 Reset: aresetn low -> all outputs 0; release -> i_ready=1 next edge.
//  2 Stream N=4,DW=8, sel cycles 0001..1000, i={8'h44,8'h33,8'h22,8'h11},
//    o_ready=1 -> o=11,22,33,44 on consecutive cycles, one cycle after accept.
//  3 Backpressure: 3 beats A,B,C, o_ready=0 -> A on o, B in skid, i_ready=0,
//    C held; o_ready=1 -> A,B,C out in order, i_ready recovers.
//  4 Bad sel: sel=0000 -> o=00,o_err=1; sel=0011 -> o=33,o_err=1;
//    err_count=2; CHECK=0 -> o_err=0, err_count=0.
//  5 Saturation/clear: ERR_CNT_W=2, 5 bad beats -> err_count=3; err_clr with
//    bad beat same cycle -> err_count=0.
//  6 Async reset asserted with TWO occupancy -> o_valid=0 immediately,
//    no stale beat after release.

Source files
------------

// File: rtl/onehot_mux_stream_if.sv
// rtl/onehot_mux_stream_if.sv - stream handshake bundle for onehot_mux_stream
interface onehot_mux_stream_if #(
    parameter int DW = 8,
    parameter int N  = 4
);
    logic [N-1:0]    sel;
    logic [N*DW-1:0] i;
    logic            i_valid;
    logic            i_ready;
    logic [DW-1:0]   o;
    logic            o_err;
    logic            o_valid;
    logic            o_ready;

    modport master (
        output sel, i, i_valid, o_ready,
        input  i_ready, o, o_err, o_valid
    );

    modport slave (
        input  sel, i, i_valid, o_ready,
        output i_ready, o, o_err, o_valid
    );
endinterface

// File: rtl/onehot_mux_stream.sv
// rtl/onehot_mux_stream.sv - registered one-hot mux with 2-entry skid stage and sel checking
module onehot_mux_stream #(
    parameter int DW        = 8,
    parameter int N         = 4,
    parameter int CHECK     = 1,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 aresetn,
    onehot_mux_stream_if.slave   bus,
    input  logic                 err_clr,
    output logic [ERR_CNT_W-1:0] err_count
);
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [DW-1:0]        r_o;
    logic [DW-1:0]        r_skid_d;
    logic                 r_o_err;
    logic                 r_skid_err;
    logic                 r_o_valid;
    logic                 r_i_ready;
    logic [ERR_CNT_W-1:0] r_err_count;
    logic [DW-1:0]        w_d;
    logic                 w_bad;
    logic                 w_in;
    logic                 w_out;
    logic                 w_load_out_in;
    logic                 w_load_out_skid;
    logic                 w_load_skid;

    assign w_in  = bus.i_valid & r_i_ready;
    assign w_out = r_o_valid & bus.o_ready;

    always_comb begin
        w_d = '0;
        for (int j = 0; j < N; j++) begin
            w_d = w_d | ({DW{bus.sel[j]}} & bus.i[j*DW +: DW]);
        end
    end

    generate
        if (CHECK != 0) begin : g_check
            assign w_bad = ($countones(bus.sel) != 1);
        end else begin : g_nocheck
            assign w_bad = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_next_state;
        end
    end

    // i_ready is never asserted in TWO, so no input transfer is considered there.
    always_comb begin
        w_next_state    = r_state;
        w_load_out_in   = 1'b0;
        w_load_out_skid = 1'b0;
        w_load_skid     = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                if (w_in) begin
                    w_next_state  = ST_ONE;
                    w_load_out_in = 1'b1;
                end
            end
            ST_ONE: begin
                if (w_in && w_out) begin
                    w_load_out_in = 1'b1;
                end else if (w_in) begin
                    w_next_state = ST_TWO;
                    w_load_skid  = 1'b1;
                end else if (w_out) begin
                    w_next_state = ST_EMPTY;
                end
            end
            ST_TWO: begin
                if (w_out) begin
                    w_next_state    = ST_ONE;
                    w_load_out_skid = 1'b1;
                end
            end
            default: begin
                w_next_state = ST_EMPTY;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_o        <= '0;
            r_o_err    <= 1'b0;
            r_skid_d   <= '0;
            r_skid_err <= 1'b0;
            r_o_valid  <= 1'b0;
            r_i_ready  <= 1'b0;
        end else begin
            r_o_valid <= (w_next_state != ST_EMPTY);
            r_i_ready <= (w_next_state != ST_TWO);
            if (w_load_out_in) begin
                r_o     <= w_d;
                r_o_err <= w_bad;
            end else if (w_load_out_skid) begin
                r_o     <= r_skid_d;
                r_o_err <= r_skid_err;
            end
            if (w_load_skid) begin
                r_skid_d   <= w_d;
                r_skid_err <= w_bad;
            end
        end
    end

    // Clear wins over a same-cycle increment; the count sticks at all-ones.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_err_count <= '0;
        end else if (err_clr) begin
            r_err_count <= '0;
        end else if (w_in && w_bad && !(&r_err_count)) begin
            r_err_count <= r_err_count + ERR_CNT_W'(1);
        end
    end

    assign bus.o       = r_o;
    assign bus.o_err   = r_o_err;
    assign bus.o_valid = r_o_valid;
    assign bus.i_ready = r_i_ready;
    assign err_count   = r_err_count;
endmodule
